sdrd_deserializer: RTL and testbench

- Downstream consumer of the serial read-data line (SDRD) driven by the serial-state sequencer PAL.
- Samples qualified SDRD bits and assembles them LSB-first into bytes.
- Buffers assembled bytes in a small FIFO and presents data and status to the host bus as two read-only registers.
- Sits between the sequencer PAL and the host bus read mux.

---
 rtl/sdrd_pkg.sv | 21 ++
 rtl/sdrd_fifo.sv | 72 +++++++
 rtl/sdrd_deserializer.sv | 147 ++++++++++++++
 tb/tb_sdrd_deserializer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sdrd_pkg.sv
// Shared constants for the SDRD deserializer: register map, status bit
// positions and default widths.
package sdrd_pkg;

    localparam int SDRD_DATA_W = 8;
    localparam int SDRD_DEPTH  = 4;
    localparam int SDRD_CNT_W  = 3;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_STAT = 1'b1;

    // Status bit positions for the default word width; ovf is always the MSB.
    localparam int STAT_OVF  = SDRD_DATA_W - 1;
    localparam int STAT_PERR = SDRD_DATA_W - 2;

    // Serial frame length: data bits plus an optional trailing parity bit.
    function automatic int frame_len(input int data_w, input bit parity);
        return data_w + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/sdrd_fifo.sv
// Circular word buffer for the SDRD deserializer. Pointers carry one extra
// MSB so full and empty are distinguished without a separate counter.
module sdrd_fifo
    import sdrd_pkg::*;
#(
    parameter int DATA_W = SDRD_DATA_W,
    parameter int DEPTH  = SDRD_DEPTH,
    parameter int CNT_W  = SDRD_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [AW:0]       occ;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign occ     = wptr_q - rptr_q;
    assign count   = CNT_W'(occ);
    assign full    = (occ == FULL_CNT);
    assign empty   = (occ == '0);
    assign rd_data = mem_q[rptr_q[AW-1:0]];

    // A pop frees its slot before the push is judged, so push-on-full with a
    // concurrent pop is accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointer and storage contents.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = push_data;
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Pointer and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/sdrd_deserializer.sv
// SDRD deserializer: assembles qualified serial bits LSB-first into words,
// buffers them in sdrd_fifo and exposes data/status read registers.
// Optional odd-parity checking is built when SDRD_PARITY_EN is defined.
module sdrd_deserializer
    import sdrd_pkg::*;
#(
    parameter int DATA_W = SDRD_DATA_W,
    parameter int DEPTH  = SDRD_DEPTH,
    parameter int CNT_W  = SDRD_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdrd,
    input  logic              sdrd_vld,
    input  logic              sdrd_sync,
    input  logic              bus_sel,
    input  logic              bus_rd,
    input  logic              bus_addr,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              rx_nempty
);

`ifdef SDRD_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    localparam int FRAME_LEN = frame_len(DATA_W, PARITY);
    localparam int BC_W      = $clog2(FRAME_LEN + 1);
    localparam int OVF_BIT   = STAT_OVF + DATA_W - SDRD_DATA_W;
    localparam int PERR_BIT  = STAT_PERR + DATA_W - SDRD_DATA_W;

    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]      bitcnt_q, bitcnt_d;
    logic [BC_W-1:0]      bc_next;
    logic                 push_q, push_d;
    logic                 ovf_q, ovf_d;
    logic [DATA_W-1:0]    bus_rdata_q, bus_rdata_d;
    logic                 rx_nempty_q;
    logic [DATA_W-1:0]    stat_word;
    logic [DATA_W-1:0]    head;
    logic                 full, empty;
    logic [CNT_W-1:0]     count;
    logic                 data_rd, stat_rd;
    logic                 perr;

    assign data_rd = bus_sel & bus_rd & (bus_addr == REG_DATA);
    assign stat_rd = bus_sel & bus_rd & (bus_addr == REG_STAT);

    sdrd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (shreg_q[DATA_W-1:0]),
        .pop       (data_rd),
        .rd_data   (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Shift path: sync restarts the frame, completion requests a push that
    // the FIFO takes on the following edge.
    always_comb begin
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        push_d   = 1'b0;
        bc_next  = sdrd_sync ? BC_W'(1) : bitcnt_q + 1'b1;
        if (sdrd_vld) begin
            shreg_d = {sdrd, shreg_q[FRAME_LEN-1:1]};
            if (bc_next == BC_W'(FRAME_LEN)) begin
                bitcnt_d = '0;
                push_d   = 1'b1;
            end else begin
                bitcnt_d = bc_next;
            end
        end else if (sdrd_sync) begin
            bitcnt_d = '0;
        end
    end

`ifdef SDRD_PARITY_EN
    logic perr_q, perr_d;

    // Sticky parity error; a new error on a status-read edge survives the clear.
    always_comb begin
        perr_d = perr_q;
        if (stat_rd) perr_d = 1'b0;
        if (push_q && !(^shreg_q)) perr_d = 1'b1;
    end

    // Parity error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= perr_d;
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    // Status word and bus read mux; overflow set wins over the read-clear.
    always_comb begin
        stat_word                = '0;
        stat_word[CNT_W-1:0]     = count;
        stat_word[OVF_BIT]       = ovf_q;
        stat_word[PERR_BIT]      = perr;
        ovf_d = ovf_q;
        if (stat_rd) ovf_d = 1'b0;
        if (push_q && full && !data_rd) ovf_d = 1'b1;
        bus_rdata_d = bus_rdata_q;
        if (data_rd) begin
            bus_rdata_d = empty ? '0 : head;
        end else if (stat_rd) begin
            bus_rdata_d = stat_word;
        end
    end

    // Shift, flag and bus output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            push_q      <= 1'b0;
            ovf_q       <= 1'b0;
            bus_rdata_q <= '0;
            rx_nempty_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            push_q      <= push_d;
            ovf_q       <= ovf_d;
            bus_rdata_q <= bus_rdata_d;
            rx_nempty_q <= ~empty;
        end
    end

    assign bus_rdata = bus_rdata_q;
    assign rx_nempty = rx_nempty_q;

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Directed bench for sdrd_deserializer (default parameters). Parity steps
// are included when SDRD_PARITY_EN is defined.
module tb_sdrd_deserializer;

    logic       clk;
    logic       rst;
    logic       sdrd;
    logic       sdrd_vld;
    logic       sdrd_sync;
    logic       bus_sel;
    logic       bus_rd;
    logic       bus_addr;
    logic [7:0] bus_rdata;
    logic       rx_nempty;

    int n_vec = 0;
    int n_err = 0;

    sdrd_deserializer dut (
        .clk       (clk),
        .rst       (rst),
        .sdrd      (sdrd),
        .sdrd_vld  (sdrd_vld),
        .sdrd_sync (sdrd_sync),
        .bus_sel   (bus_sel),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_rdata (bus_rdata),
        .rx_nempty (rx_nempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sync);
        sdrd      = b;
        sdrd_vld  = 1'b1;
        sdrd_sync = sync;
        tick(1);
        sdrd      = 1'b0;
        sdrd_vld  = 1'b0;
        sdrd_sync = 1'b0;
    endtask

    // Full frame, back to back, with a correct odd-parity bit when enabled.
    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
`ifdef SDRD_PARITY_EN
        send_bit(~^b, 1'b0);
`endif
    endtask

    task automatic bus_read(input logic a, output logic [7:0] d);
        bus_sel  = 1'b1;
        bus_rd   = 1'b1;
        bus_addr = a;
        tick(1);
        bus_sel  = 1'b0;
        bus_rd   = 1'b0;
        bus_addr = 1'b0;
        d = bus_rdata;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] a5;
        a5 = 8'hA5;
        rst = 1'b1; sdrd = 1'b0; sdrd_vld = 1'b0; sdrd_sync = 1'b0;
        bus_sel = 1'b0; bus_rd = 1'b0; bus_addr = 1'b0;
        tick(3);
        check("rst_rdata", bus_rdata, 8'h00);
        check("rst_nempty", {7'b0, rx_nempty}, 8'h00);
        rst = 1'b0;
        tick(1);

        // Reset in the middle of a frame discards the partial bits.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        check("midrst_nempty", {7'b0, rx_nempty}, 8'h00);
        bus_read(1'b1, d);  check("midrst_stat", d, 8'h00);
        send_byte(8'hA5);
        tick(2);
        bus_read(1'b0, d);  check("midrst_data", d, 8'hA5);

        // LSB-first byte with gaps between bits; nempty two clocks after last bit.
        for (int i = 0; i < 8; i++) begin
            send_bit(a5[i], 1'b0);
`ifndef SDRD_PARITY_EN
            if (i != 7) tick(1);
`else
            tick(1);
`endif
        end
`ifdef SDRD_PARITY_EN
        send_bit(~^a5, 1'b0);
`endif
        check("lsb_nempty_e0", {7'b0, rx_nempty}, 8'h00);
        tick(1);
        check("lsb_nempty_e1", {7'b0, rx_nempty}, 8'h00);
        tick(1);
        check("lsb_nempty_e2", {7'b0, rx_nempty}, 8'h01);
        bus_read(1'b1, d);  check("lsb_stat1", d, 8'h01);
        bus_sel = 1'b0; bus_rd = 1'b1; bus_addr = 1'b0;
        tick(1);
        bus_rd = 1'b0;
        check("unsel_hold", bus_rdata, 8'h01);
        bus_read(1'b0, d);  check("lsb_data", d, 8'hA5);
        bus_read(1'b1, d);  check("lsb_stat0", d, 8'h00);
        check("lsb_nempty_low", {7'b0, rx_nempty}, 8'h00);

        // Overflow: five words into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            tick(2);
        end
        bus_read(1'b1, d);  check("ovf_stat", d, 8'h84);
        bus_read(1'b1, d);  check("ovf_stat_clr", d, 8'h04);
        for (int i = 1; i <= 4; i++) begin
            bus_read(1'b0, d);  check("ovf_data", d, 8'(i));
        end
        bus_read(1'b0, d);  check("ovf_empty_rd", d, 8'h00);
        bus_read(1'b1, d);  check("ovf_stat_empty", d, 8'h00);

        // Push lands on the same edge as a data read while full.
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h11 + 8'(i));
            tick(2);
        end
        bus_read(1'b1, d);  check("pp_stat_full", d, 8'h04);
        send_byte(8'h15);
        bus_read(1'b0, d);  check("pp_data_first", d, 8'h11);
        bus_read(1'b1, d);  check("pp_stat_noovf", d, 8'h04);
        for (int i = 0; i < 4; i++) begin
            bus_read(1'b0, d);  check("pp_order", d, 8'h12 + 8'(i));
        end
        bus_read(1'b0, d);  check("pp_empty_rd", d, 8'h00);

        // Resync with a bit: partial bits dropped, 0x81 assembled.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
`ifdef SDRD_PARITY_EN
        send_bit(1'b1, 1'b0);
`endif
        tick(2);
        bus_read(1'b0, d);  check("resync_data", d, 8'h81);
        bus_read(1'b1, d);  check("resync_stat", d, 8'h00);

        // Sync without a valid bit clears the counter only.
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        sdrd_sync = 1'b1;
        tick(1);
        sdrd_sync = 1'b0;
        send_byte(8'h3C);
        tick(2);
        bus_read(1'b0, d);  check("sync_only_data", d, 8'h3C);

`ifdef SDRD_PARITY_EN
        for (int i = 0; i < 9; i++) send_bit(1'b0, 1'b0);
        tick(2);
        bus_read(1'b1, d);  check("par_bad_stat", d, 8'h41);
        bus_read(1'b0, d);  check("par_bad_data", d, 8'h00);
        bus_read(1'b1, d);  check("par_clr_stat", d, 8'h00);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        tick(2);
        bus_read(1'b1, d);  check("par_good_stat", d, 8'h01);
        bus_read(1'b0, d);  check("par_good_data", d, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
